// File: rtl/demapper_ser_counter_if.sv
// Symbol-rate bus between the rx decision path and the demapper / SER counter.
// The master drives the symbol stream; the slave returns sliced bits, alignment and error counts.
interface demapper_ser_counter_if #(
    parameter int CNT_W = 20
);
    logic                sym_clk_en;
    logic                clear_accum;
    logic signed [17:0]  dec_var;
    logic signed [17:0]  ref_level;
    logic [1:0]          tx_bits;
    logic [1:0]          rx_bits;
    logic [4:0]          delay_sel;
    logic                locked;
    logic [CNT_W-1:0]    sym_err_cnt;
    logic [CNT_W-1:0]    bit_err_cnt;
    logic                window_done;

    modport master (
        output sym_clk_en, clear_accum, dec_var, ref_level, tx_bits,
        input  rx_bits, delay_sel, locked, sym_err_cnt, bit_err_cnt, window_done
    );

    modport slave (
        input  sym_clk_en, clear_accum, dec_var, ref_level, tx_bits,
        output rx_bits, delay_sel, locked, sym_err_cnt, bit_err_cnt, window_done
    );
endinterface

// File: rtl/demapper_ser_counter.sv
// Gray 4-level demapper with auto-aligned symbol/bit error counting over fixed windows.
// Build option ERR_CNT_SAT_EN: error accumulators saturate instead of wrapping.
module demapper_ser_counter #(
    parameter int DELAY_MAX = 31,
    parameter int ALIGN_WIN = 64,
    parameter int WIN_LOG2  = 16,
    parameter int LOSS_THR  = 8,
    parameter int CNT_W     = 20
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    demapper_ser_counter_if.slave bus
);
    localparam int                 TRIAL_W    = $clog2(ALIGN_WIN + 1);
    localparam logic [TRIAL_W-1:0] TRIAL_LAST = TRIAL_W'(ALIGN_WIN - 1);
    localparam logic [4:0]         DMAX       = 5'(DELAY_MAX);
    localparam logic [CNT_W-1:0]   LOSS_LIM   = CNT_W'(LOSS_THR);

    typedef enum logic {SEARCH = 1'b0, MEASURE = 1'b1} state_e;

    state_e              state_q, state_d;
    logic [1:0]          hist_q [DELAY_MAX+1];
    logic [1:0]          rx_bits_q;
    logic [4:0]          delay_q, delay_d;
    logic [TRIAL_W-1:0]  trial_q, trial_d;
    logic                trial_err_q, trial_err_d;
    logic [WIN_LOG2-1:0] win_q, win_d;
    logic [CNT_W-1:0]    sym_acc_q, sym_acc_d, bit_acc_q, bit_acc_d;
    logic [CNT_W-1:0]    sym_out_q, sym_out_d, bit_out_q, bit_out_d;
    logic                window_done_q, window_done_d;
    logic                locked_w;

    logic [1:0]          slice_w, err_xor;
    logic                sym_err, trial_last, trial_err_now, win_last;
    logic [1:0]          bit_err;
    logic [CNT_W-1:0]    sym_latch, bit_latch;

    function automatic logic [1:0] slice(input logic signed [17:0] dec,
                                         input logic signed [17:0] lvl);
        logic signed [18:0] d19;
        logic signed [18:0] t19;
        d19 = {dec[17], dec};
        t19 = {lvl, 1'b0};
        if (d19 >= t19)          slice = 2'b10;
        else if (d19 >= 19'sd0)  slice = 2'b11;
        else if (d19 >= -t19)    slice = 2'b01;
        else                     slice = 2'b00;
    endfunction

    function automatic logic [CNT_W-1:0] acc_add(input logic [CNT_W-1:0] acc,
                                                 input logic [1:0]       inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, acc} + {{(CNT_W-1){1'b0}}, inc};
`ifdef ERR_CNT_SAT_EN
        acc_add = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
`else
        acc_add = sum[CNT_W-1:0];
`endif
    endfunction

    // Compare against the pre-shift history entry chosen by the current delay.
    assign slice_w       = slice(bus.dec_var, bus.ref_level);
    assign err_xor       = slice_w ^ hist_q[delay_q];
    assign sym_err       = |err_xor;
    assign bit_err       = {1'b0, err_xor[1]} + {1'b0, err_xor[0]};
    assign trial_last    = (trial_q == TRIAL_LAST);
    assign trial_err_now = trial_err_q | sym_err;
    assign win_last      = &win_q;
    assign sym_latch     = acc_add(sym_acc_q, {1'b0, sym_err});
    assign bit_latch     = acc_add(bit_acc_q, bit_err);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= SEARCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.sym_clk_en && !bus.clear_accum) begin
            case (state_q)
                SEARCH:  if (trial_last && !trial_err_now) state_d = MEASURE;
                MEASURE: if (win_last && (sym_latch > LOSS_LIM)) state_d = SEARCH;
                default: state_d = SEARCH;
            endcase
        end
    end

    always_comb begin
        locked_w = (state_q == MEASURE);
    end

    always_comb begin
        delay_d       = delay_q;
        trial_d       = trial_q;
        trial_err_d   = trial_err_q;
        win_d         = win_q;
        sym_acc_d     = sym_acc_q;
        bit_acc_d     = bit_acc_q;
        sym_out_d     = sym_out_q;
        bit_out_d     = bit_out_q;
        window_done_d = 1'b0;
        if (bus.clear_accum) begin
            trial_d     = '0;
            trial_err_d = 1'b0;
            win_d       = '0;
            sym_acc_d   = '0;
            bit_acc_d   = '0;
        end else if (bus.sym_clk_en) begin
            if (state_q == SEARCH) begin
                if (trial_last) begin
                    trial_d     = '0;
                    trial_err_d = 1'b0;
                    if (trial_err_now) begin
                        delay_d = (delay_q == DMAX) ? 5'd0 : delay_q + 5'd1;
                    end else begin
                        win_d     = '0;
                        sym_acc_d = '0;
                        bit_acc_d = '0;
                    end
                end else begin
                    trial_d     = trial_q + 1'b1;
                    trial_err_d = trial_err_now;
                end
            end else begin
                win_d = win_q + 1'b1;
                if (win_last) begin
                    sym_out_d     = sym_latch;
                    bit_out_d     = bit_latch;
                    window_done_d = 1'b1;
                    sym_acc_d     = '0;
                    bit_acc_d     = '0;
                end else begin
                    sym_acc_d = sym_latch;
                    bit_acc_d = bit_latch;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rx_bits_q     <= '0;
            delay_q       <= '0;
            trial_q       <= '0;
            trial_err_q   <= 1'b0;
            win_q         <= '0;
            sym_acc_q     <= '0;
            bit_acc_q     <= '0;
            sym_out_q     <= '0;
            bit_out_q     <= '0;
            window_done_q <= 1'b0;
            for (int k = 0; k <= DELAY_MAX; k++) hist_q[k] <= '0;
        end else begin
            delay_q       <= delay_d;
            trial_q       <= trial_d;
            trial_err_q   <= trial_err_d;
            win_q         <= win_d;
            sym_acc_q     <= sym_acc_d;
            bit_acc_q     <= bit_acc_d;
            sym_out_q     <= sym_out_d;
            bit_out_q     <= bit_out_d;
            window_done_q <= window_done_d;
            if (bus.sym_clk_en) begin
                rx_bits_q <= slice_w;
                hist_q[0] <= bus.tx_bits;
                for (int k = 1; k <= DELAY_MAX; k++) hist_q[k] <= hist_q[k-1];
            end
        end
    end

    assign bus.rx_bits     = rx_bits_q;
    assign bus.delay_sel   = delay_q;
    assign bus.locked      = locked_w;
    assign bus.sym_err_cnt = sym_out_q;
    assign bus.bit_err_cnt = bit_out_q;
    assign bus.window_done = window_done_q;
endmodule
